// File: rtl/trap_flush_ctrl_pkg.sv
// Shared definitions for the trap/flush sequencer: exception codes that start a
// flush sequence, and the sequencer state encoding.
package trap_flush_ctrl_pkg;

    localparam int unsigned EXCEPTION_W = 4;

    localparam logic [EXCEPTION_W-1:0] EXCEPTION_NONE  = EXCEPTION_W'(0);
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FENCE = EXCEPTION_W'(10);
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FPU   = EXCEPTION_W'(11);

    typedef enum logic [1:0] {
        TFC_IDLE     = 2'd0,
        TFC_DRAIN    = 2'd1,
        TFC_FLUSH    = 2'd2,
        TFC_REDIRECT = 2'd3
    } tfc_state_e;

    // Events that require a full drain/flush/redirect sequence
    function automatic logic is_flush_event(input logic                   branch,
                                            input logic [EXCEPTION_W-1:0] code);
        return branch | (code == EXCEPTION_FENCE) | (code == EXCEPTION_FPU);
    endfunction

endpackage

// File: rtl/trap_flush_ctrl_mem_outst_counter.sv
// Outstanding data-memory request counter: saturating up/down counter with a
// flag telling whether the count after this cycle's update is zero.
module mem_outst_counter #(
    parameter int unsigned OUTST_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic zero_nxt
);

    localparam logic [OUTST_W-1:0] CNT_MAX = '1;

    logic [OUTST_W-1:0] cnt;
    logic [OUTST_W-1:0] cnt_nxt;

    // Next count: req-only counts up, rsp-only counts down, both/neither hold
    always_comb begin
        cnt_nxt = cnt;
        if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + OUTST_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt_nxt = cnt - OUTST_W'(1);
        end
        zero_nxt = (cnt_nxt == '0);
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // A response with nothing in flight, or a request beyond capacity, is a protocol bug upstream
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(dec && !inc && (cnt == '0)));
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                     !(inc && !dec && (cnt == CNT_MAX)));

endmodule

// File: rtl/trap_flush_ctrl.sv
// Trap/flush sequencer downstream of the CSR stage. Each trap, ERET, FENCE or
// FPU-flag event becomes: stall issue -> drain data-memory ops -> 1-cycle flush
// -> fetch redirect handshake.
// Optional build macro TRAP_FLUSH_PERF_EN adds trap and stall-cycle counters.
module trap_flush_ctrl
    import trap_flush_ctrl_pkg::*;
#(
    parameter int unsigned OUTST_W = 2,
    parameter int unsigned PC_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   csr_branch_i,
    input  logic [PC_W-1:0]        csr_target_i,
    input  logic [EXCEPTION_W-1:0] csr_exception_i,
    input  logic [PC_W-1:0]        exception_pc_i,
    input  logic                   d_mem_req_i,
    input  logic                   d_mem_rsp_i,
    input  logic                   fetch_ready_i,
    output logic                   stall_o,
    output logic                   flush_o,
    output logic                   redirect_valid_o,
    output logic [PC_W-1:0]        redirect_pc_o,
    output logic                   busy_o
`ifdef TRAP_FLUSH_PERF_EN
    ,
    output logic [31:0]            perf_trap_cnt_o,
    output logic [31:0]            perf_stall_cyc_o
`endif
);

    tfc_state_e      state;
    tfc_state_e      state_nxt;
    logic            evt_c;
    logic [PC_W-1:0] target_c;
    logic            cnt_zero_nxt;
    logic            flush_nxt;
    logic            redirect_valid_nxt;
    logic            busy_nxt;
    logic [PC_W-1:0] redirect_pc_nxt;

    mem_outst_counter #(
        .OUTST_W (OUTST_W)
    ) u_outst (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (d_mem_req_i),
        .dec      (d_mem_rsp_i),
        .zero_nxt (cnt_zero_nxt)
    );

    // Event detect and redirect target; an explicit branch wins over the fall-through PC
    always_comb begin
        evt_c    = is_flush_event(csr_branch_i, csr_exception_i);
        target_c = csr_branch_i ? csr_target_i : (exception_pc_i + PC_W'(4));
    end

    // Issue stops in the event cycle itself; held low while in reset
    assign stall_o = rst_n & ((state != TFC_IDLE) | evt_c);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= TFC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; events outside IDLE are ignored (CSR stage is held by stall)
    always_comb begin
        state_nxt = state;
        case (state)
            TFC_IDLE: begin
                if (evt_c) begin
                    state_nxt = cnt_zero_nxt ? TFC_FLUSH : TFC_DRAIN;
                end
            end
            TFC_DRAIN: begin
                if (cnt_zero_nxt) begin
                    state_nxt = TFC_FLUSH;
                end
            end
            TFC_FLUSH: begin
                state_nxt = TFC_REDIRECT;
            end
            TFC_REDIRECT: begin
                if (fetch_ready_i) begin
                    state_nxt = TFC_IDLE;
                end
            end
            default: begin
                state_nxt = TFC_IDLE;
            end
        endcase
    end

    // Output decode for the registered outputs
    always_comb begin
        flush_nxt          = (state_nxt == TFC_FLUSH);
        redirect_valid_nxt = (state_nxt == TFC_REDIRECT);
        busy_nxt           = (state_nxt != TFC_IDLE);
        redirect_pc_nxt    = redirect_pc_o;
        if ((state == TFC_IDLE) && evt_c) begin
            redirect_pc_nxt = target_c;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            busy_o           <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            flush_o          <= flush_nxt;
            redirect_valid_o <= redirect_valid_nxt;
            busy_o           <= busy_nxt;
            redirect_pc_o    <= redirect_pc_nxt;
        end
    end

`ifdef TRAP_FLUSH_PERF_EN
    // Performance counters: sequences started and cycles spent stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_trap_cnt_o  <= '0;
            perf_stall_cyc_o <= '0;
        end else begin
            if ((state == TFC_IDLE) && evt_c) begin
                perf_trap_cnt_o <= perf_trap_cnt_o + 32'd1;
            end
            if (stall_o) begin
                perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
            end
        end
    end
`endif

endmodule
